layer_link: RTL and testbench
=============================

Name: layer_link

Overview:
- Sequencing/buffering stage between two adjacent matrix-multiply layers: lower layer N, upper layer N+1.
- Forward phase: captures layer N's packed 7x9 activation vector over its valid/ack handshake, then launches layer N+1 with a one-cycle mult pulse.
- Backward phase: captures layer N+1's delta vector, then launches layer N with a one-cycle backprop pulse.
- Each layer's valid/ack bus is shared by two links. Each link therefore ignores the message that belongs to its neighbouring link, using a fixed message order.

Parameters:
- PK_WIDTH, 7, bits per vector element
- PK_LEN, 9, elements per vector
- LOWER_IS_INPUT, 0, 1 = lower side is the network input source, which emits no delta message, so the lower-skip states are bypassed

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- lo_vec_in  in  63  packed output bus of layer N
- lo_valid  in  1  valid from layer N
- lo_ack  out  1  ack to layer N; top level ORs it with the ack from the link below
- lo_vec_out  out  63  packed input vector driven to layer N (delta)
- lo_backprop  out  1  backprop pulse to layer N
- hi_vec_in  in  63  packed output bus of layer N+1
- hi_valid  in  1  valid from layer N+1
- hi_ack  out  1  ack to layer N+1; top level ORs it with the ack from the link above
- hi_vec_out  out  63  packed input vector driven to layer N+1 (activations)
- hi_mult  out  1  mult pulse to layer N+1
- phase  out  1  0 = forward half, 1 = backward half
- round_cnt  out  8  number of completed forward+backward round trips

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FWD_WAIT
  - all outputs 0: lo_ack, hi_ack, lo_backprop, hi_mult, phase, round_cnt
  - fwd_reg, bwd_reg cleared, so hi_vec_out and lo_vec_out read 0
  - A reset mid-transfer abandons it silently; no pulse is emitted after reset is released.
- Output sources:
  - hi_vec_out = fwd_reg and lo_vec_out = bwd_reg, continuously.
  - Each register changes only at its capture edge, so the driven vector is stable before and during the matching mult/backprop pulse.
- Handshake rules:
  - Ack is a registered single-cycle pulse.
  - After an ack, the link waits for the corresponding valid to be seen low before it takes any other action on that side.
  - A valid still high in the cycle after ack is never re-captured.
- State machine, one transition per clk unless waiting:
  - FWD_WAIT: on lo_valid=1, latch fwd_reg<=lo_vec_in and go to FWD_ACK.
  - FWD_ACK: lo_ack=1 for this cycle only; go to FWD_DROP.
  - FWD_DROP: wait for lo_valid=0, then go to FWD_ISSUE.
  - FWD_ISSUE: hi_mult=1 for one cycle; go to HI_SKIP_RISE.
  - HI_SKIP_RISE: wait for hi_valid=1. This is layer N+1's forward output, owned by the link above; no ack. Go to HI_SKIP_FALL.
  - HI_SKIP_FALL: wait for hi_valid=0; set phase=1; go to BWD_WAIT.
  - BWD_WAIT: on hi_valid=1, latch bwd_reg<=hi_vec_in and go to BWD_ACK.
  - BWD_ACK: hi_ack=1 for one cycle; go to BWD_DROP.
  - BWD_DROP: wait for hi_valid=0, then go to BWD_ISSUE.
  - BWD_ISSUE: lo_backprop=1 for one cycle; go to LO_SKIP_RISE, or to DONE if LOWER_IS_INPUT=1.
  - LO_SKIP_RISE / LO_SKIP_FALL: ignore layer N's outgoing delta message (rise then fall); no ack.
  - DONE: round_cnt++ (wraps 255->0), phase=0; go to FWD_WAIT.
- Latency:
  - lo_valid rising to hi_mult = 3 cycles minimum (capture, ack, drop seen low next cycle, issue).
  - The same 3-cycle minimum applies from hi_valid rising to lo_backprop.
- Simultaneous events: valid asserted on the side the current state is not watching is ignored. This is not an error; the ordering protocol guarantees it belongs to the neighbouring link.
- Data is passed through bit-exact; no arithmetic or saturation in this block.

Decomposition:
- Shared package nn_pkg holds:
  - PK_WIDTH, PK_LEN, and VEC_W = PK_WIDTH*PK_LEN = 63
  - link state encoding, 4-bit localparams
- Natural sub-module hs_capture: one per direction.
  - Ports: clk, reset, vec_in, valid, arm, ack, vec_reg, done.
  - Performs capture / one-cycle ack / wait-for-drop.
  - The top-level FSM sequences the two instances and the skip states.

Test Plan:
- Forward capture: lo_vec_in=63'h0123456789ABCDEF, lo_valid held 1 until lo_ack is seen → exactly one lo_ack pulse; hi_vec_out=63'h0123456789ABCDEF by the ack cycle; one hi_mult pulse 3 cycles after lo_valid rise; no hi_ack.
- Skip then delta: after hi_mult, hi_valid high 4 cycles with vector A, then low, then high with vector B → hi_ack only for B; lo_vec_out=B; one lo_backprop pulse; phase rises after A falls.
- Round trip with LOWER_IS_INPUT=0: the first lo_valid after lo_backprop is not acked; the second is captured; round_cnt=1 after the first skip completes; 256 round trips → round_cnt wraps to 0.
- Sticky valid: lo_valid held high 10 cycles after the ack → single lo_ack, single hi_mult, issued only after lo_valid falls.
- Reset mid-operation: assert reset in FWD_DROP → all outputs 0 immediately, without waiting for a clk edge; after release, no hi_mult until a fresh lo_valid.
- LOWER_IS_INPUT=1: after lo_backprop → DONE then FWD_WAIT directly; the next lo_valid is captured immediately.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants for the layer link: vector geometry and the link state encoding.
package nn_pkg;

  localparam int PK_WIDTH = 7;
  localparam int PK_LEN   = 9;
  localparam int VEC_W    = PK_WIDTH * PK_LEN;

  localparam logic [3:0] FWD_WAIT     = 4'd0;
  localparam logic [3:0] FWD_ACK      = 4'd1;
  localparam logic [3:0] FWD_DROP     = 4'd2;
  localparam logic [3:0] FWD_ISSUE    = 4'd3;
  localparam logic [3:0] HI_SKIP_RISE = 4'd4;
  localparam logic [3:0] HI_SKIP_FALL = 4'd5;
  localparam logic [3:0] BWD_WAIT     = 4'd6;
  localparam logic [3:0] BWD_ACK      = 4'd7;
  localparam logic [3:0] BWD_DROP     = 4'd8;
  localparam logic [3:0] BWD_ISSUE    = 4'd9;
  localparam logic [3:0] LO_SKIP_RISE = 4'd10;
  localparam logic [3:0] LO_SKIP_FALL = 4'd11;
  localparam logic [3:0] DONE         = 4'd12;

endpackage

// File: rtl/hs_capture.sv
// One direction of the valid/ack handshake: capture the vector while armed,
// pulse ack for one cycle, then wait for valid to drop before reporting done.
module hs_capture
  import nn_pkg::*;
#(
  parameter int W = VEC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] vec_in,
  input  logic         valid,
  input  logic         arm,
  output logic         ack,
  output logic [W-1:0] vec_reg,
  output logic         done
);

  localparam logic [1:0] HS_IDLE = 2'd0;
  localparam logic [1:0] HS_ACK  = 2'd1;
  localparam logic [1:0] HS_DROP = 2'd2;

  logic [1:0] hs_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_state <= HS_IDLE;
      ack      <= 1'b0;
      vec_reg  <= '0;
    end else begin
      ack <= 1'b0;
      case (hs_state)
        HS_IDLE: begin
          if (arm && valid) begin
            vec_reg  <= vec_in;
            ack      <= 1'b1;
            hs_state <= HS_ACK;
          end
        end
        HS_ACK:  hs_state <= HS_DROP;
        HS_DROP: if (!valid) hs_state <= HS_IDLE;
        default: hs_state <= HS_IDLE;
      endcase
    end
  end

  // Valid still high after ack keeps us in HS_DROP, so it is never re-captured.
  assign done = (hs_state == HS_DROP) && !valid;

endmodule

// File: rtl/layer_link.sv
// Forward/backward sequencer between layer N (lo side) and layer N+1 (hi side).
//
// state        | meaning
// FWD_WAIT     | armed for layer N activations
// FWD_ACK      | lo_ack pulse
// FWD_DROP     | waiting for lo_valid low
// FWD_ISSUE    | hi_mult pulse
// HI_SKIP_RISE | waiting for layer N+1 forward output (owned by link above)
// HI_SKIP_FALL | waiting for it to drop; phase goes to backward
// BWD_WAIT     | armed for layer N+1 delta
// BWD_ACK      | hi_ack pulse
// BWD_DROP     | waiting for hi_valid low
// BWD_ISSUE    | lo_backprop pulse
// LO_SKIP_RISE | waiting for layer N delta (owned by link below)
// LO_SKIP_FALL | waiting for it to drop
// DONE         | count round trip, back to forward
module layer_link #(
  parameter int PK_WIDTH       = nn_pkg::PK_WIDTH,
  parameter int PK_LEN         = nn_pkg::PK_LEN,
  parameter int LOWER_IS_INPUT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PK_WIDTH*PK_LEN-1:0] lo_vec_in,
  input  logic                       lo_valid,
  output logic                       lo_ack,
  output logic [PK_WIDTH*PK_LEN-1:0] lo_vec_out,
  output logic                       lo_backprop,
  input  logic [PK_WIDTH*PK_LEN-1:0] hi_vec_in,
  input  logic                       hi_valid,
  output logic                       hi_ack,
  output logic [PK_WIDTH*PK_LEN-1:0] hi_vec_out,
  output logic                       hi_mult,
  output logic                       phase,
  output logic [7:0]                 round_cnt
);

  import nn_pkg::*;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       fwd_done;
  logic       bwd_done;

  hs_capture #(.W(PK_WIDTH*PK_LEN)) u_fwd (
    .clk     (clk),
    .reset   (reset),
    .vec_in  (lo_vec_in),
    .valid   (lo_valid),
    .arm     (state == FWD_WAIT),
    .ack     (lo_ack),
    .vec_reg (hi_vec_out),
    .done    (fwd_done)
  );

  hs_capture #(.W(PK_WIDTH*PK_LEN)) u_bwd (
    .clk     (clk),
    .reset   (reset),
    .vec_in  (hi_vec_in),
    .valid   (hi_valid),
    .arm     (state == BWD_WAIT),
    .ack     (hi_ack),
    .vec_reg (lo_vec_out),
    .done    (bwd_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FWD_WAIT:     if (lo_valid) state_nxt = FWD_ACK;
      FWD_ACK:      state_nxt = FWD_DROP;
      FWD_DROP:     if (fwd_done) state_nxt = FWD_ISSUE;
      FWD_ISSUE:    state_nxt = HI_SKIP_RISE;
      HI_SKIP_RISE: if (hi_valid) state_nxt = HI_SKIP_FALL;
      HI_SKIP_FALL: if (!hi_valid) state_nxt = BWD_WAIT;
      BWD_WAIT:     if (hi_valid) state_nxt = BWD_ACK;
      BWD_ACK:      state_nxt = BWD_DROP;
      BWD_DROP:     if (bwd_done) state_nxt = BWD_ISSUE;
      // A network-input lower layer never sends a delta, so there is nothing to skip.
      BWD_ISSUE:    state_nxt = (LOWER_IS_INPUT != 0) ? DONE : LO_SKIP_RISE;
      LO_SKIP_RISE: if (lo_valid) state_nxt = LO_SKIP_FALL;
      LO_SKIP_FALL: if (!lo_valid) state_nxt = DONE;
      DONE:         state_nxt = FWD_WAIT;
      default:      state_nxt = FWD_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FWD_WAIT;
      phase     <= 1'b0;
      round_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == HI_SKIP_FALL && !hi_valid) begin
        phase <= 1'b1;
      end else if (state == DONE) begin
        phase     <= 1'b0;
        round_cnt <= round_cnt + 8'd1;
      end
    end
  end

  assign hi_mult     = (state == FWD_ISSUE);
  assign lo_backprop = (state == BWD_ISSUE);

endmodule

// File: tb/tb_layer_link.sv
// Scoreboard bench for layer_link: drivers queue expected pulses (vector and
// cycle), a monitor pops and compares whenever a DUT pulses ack/mult/backprop.
module tb_layer_link;

  typedef struct {
    int          dut;
    logic [62:0] v;
    int          c;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [62:0] lo_vec_in [2];
  logic [62:0] hi_vec_in [2];
  logic [62:0] lo_vec_out [2];
  logic [62:0] hi_vec_out [2];
  logic        lo_valid [2];
  logic        hi_valid [2];
  logic        lo_ack [2];
  logic        hi_ack [2];
  logic        lo_backprop [2];
  logic        hi_mult [2];
  logic        phase [2];
  logic [7:0]  round_cnt [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t q_lo_ack[$];
  exp_t q_hi_ack[$];
  exp_t q_mult[$];
  exp_t q_bp[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_link #(.LOWER_IS_INPUT(0)) dut0 (
    .clk(clk), .reset(reset),
    .lo_vec_in(lo_vec_in[0]), .lo_valid(lo_valid[0]), .lo_ack(lo_ack[0]),
    .lo_vec_out(lo_vec_out[0]), .lo_backprop(lo_backprop[0]),
    .hi_vec_in(hi_vec_in[0]), .hi_valid(hi_valid[0]), .hi_ack(hi_ack[0]),
    .hi_vec_out(hi_vec_out[0]), .hi_mult(hi_mult[0]),
    .phase(phase[0]), .round_cnt(round_cnt[0])
  );

  layer_link #(.LOWER_IS_INPUT(1)) dut1 (
    .clk(clk), .reset(reset),
    .lo_vec_in(lo_vec_in[1]), .lo_valid(lo_valid[1]), .lo_ack(lo_ack[1]),
    .lo_vec_out(lo_vec_out[1]), .lo_backprop(lo_backprop[1]),
    .hi_vec_in(hi_vec_in[1]), .hi_valid(hi_valid[1]), .hi_ack(hi_ack[1]),
    .hi_vec_out(hi_vec_out[1]), .hi_mult(hi_mult[1]),
    .phase(phase[1]), .round_cnt(round_cnt[1])
  );

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", nm, d, act, exp);
    end
  endtask

  task automatic tmo(input string nm, input int d);
    checks++;
    failures++;
    $display("FAIL %s dut%0d actual=no_pulse required=pulse", nm, d);
  endtask

  task automatic unexp(input string nm, input int d);
    checks++;
    failures++;
    $display("FAIL %s dut%0d actual=unexpected_pulse required=none", nm, d);
  endtask

  task automatic match(input string nm, input int d, input exp_t e, input logic [62:0] act);
    chk({nm, "_dut"}, d, d, e.dut);
    chk({nm, "_cyc"}, d, cyc, e.c);
    chk({nm, "_vec"}, d, {1'b0, act}, {1'b0, e.v});
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (lo_ack[k]) begin
        if (q_lo_ack.size() == 0) unexp("lo_ack", k);
        else begin e = q_lo_ack.pop_front(); match("lo_ack", k, e, hi_vec_out[k]); end
      end
      if (hi_ack[k]) begin
        if (q_hi_ack.size() == 0) unexp("hi_ack", k);
        else begin e = q_hi_ack.pop_front(); match("hi_ack", k, e, lo_vec_out[k]); end
      end
      if (hi_mult[k]) begin
        if (q_mult.size() == 0) unexp("hi_mult", k);
        else begin e = q_mult.pop_front(); match("hi_mult", k, e, hi_vec_out[k]); end
      end
      if (lo_backprop[k]) begin
        if (q_bp.size() == 0) unexp("lo_backprop", k);
        else begin e = q_bp.pop_front(); match("lo_backprop", k, e, lo_vec_out[k]); end
      end
    end
  end

  // Tasks start at a negedge and return at the negedge where the final pulse is visible.
  task automatic fwd(input int d, input logic [62:0] v, input int e);
    exp_t x;
    int   c0;
    int   n;
    c0 = cyc;
    lo_vec_in[d] = v;
    lo_valid[d]  = 1'b1;
    x.dut = d; x.v = v; x.c = c0 + 1;
    q_lo_ack.push_back(x);
    n = 0;
    do begin @(negedge clk); n++; end while (!lo_ack[d] && n < 20);
    if (!lo_ack[d]) tmo("fwd_ack_wait", d);
    repeat (e) @(negedge clk);
    lo_valid[d] = 1'b0;
    x.c = c0 + 2 + ((e == 0) ? 1 : e);
    q_mult.push_back(x);
    n = 0;
    do begin @(negedge clk); n++; end while (!hi_mult[d] && n < 20);
    if (!hi_mult[d]) tmo("fwd_mult_wait", d);
  endtask

  task automatic bwd(input int d, input logic [62:0] v, input int e);
    exp_t x;
    int   c0;
    int   n;
    c0 = cyc;
    hi_vec_in[d] = v;
    hi_valid[d]  = 1'b1;
    x.dut = d; x.v = v; x.c = c0 + 1;
    q_hi_ack.push_back(x);
    n = 0;
    do begin @(negedge clk); n++; end while (!hi_ack[d] && n < 20);
    if (!hi_ack[d]) tmo("bwd_ack_wait", d);
    repeat (e) @(negedge clk);
    hi_valid[d] = 1'b0;
    x.c = c0 + 2 + ((e == 0) ? 1 : e);
    q_bp.push_back(x);
    n = 0;
    do begin @(negedge clk); n++; end while (!lo_backprop[d] && n < 20);
    if (!lo_backprop[d]) tmo("bwd_bp_wait", d);
  endtask

  task automatic skip_hi(input int d, input logic [62:0] v, input int len);
    hi_vec_in[d] = v;
    hi_valid[d]  = 1'b1;
    repeat (len) @(negedge clk);
    chk("phase_before_fall", d, phase[d], 1'b0);
    hi_valid[d] = 1'b0;
    @(negedge clk);
    chk("phase_after_fall", d, phase[d], 1'b1);
  endtask

  task automatic skip_lo(input int d, input logic [62:0] v, input int len);
    lo_vec_in[d] = v;
    lo_valid[d]  = 1'b1;
    repeat (len) @(negedge clk);
    lo_valid[d] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [62:0] v;
    logic [6:0]  b7;
    int          n;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      lo_vec_in[k] = '0; hi_vec_in[k] = '0;
      lo_valid[k]  = 1'b0; hi_valid[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_lo_ack", k, lo_ack[k], 0);
      chk("rst_hi_ack", k, hi_ack[k], 0);
      chk("rst_backprop", k, lo_backprop[k], 0);
      chk("rst_mult", k, hi_mult[k], 0);
      chk("rst_phase", k, phase[k], 0);
      chk("rst_round", k, round_cnt[k], 0);
      chk("rst_hi_vec", k, hi_vec_out[k], 0);
      chk("rst_lo_vec", k, lo_vec_out[k], 0);
    end
    reset = 1'b1;
    @(negedge clk);

    // Round 1: plain forward, 4-cycle skip of A, delta B, lower skip.
    fwd(0, 63'h0123456789ABCDEF, 0);
    skip_hi(0, 63'h2AAAAAAAAAAAAAAA, 4);
    bwd(0, 63'h5555555555555555, 0);
    chk("lo_vec_hold", 0, lo_vec_out[0], 63'h5555555555555555);
    chk("hi_vec_hold", 0, hi_vec_out[0], 63'h0123456789ABCDEF);
    skip_lo(0, 63'h1111111111111111, 2);
    chk("round_1", 0, round_cnt[0], 8'd1);
    chk("phase_done_1", 0, phase[0], 0);

    // Round 2: sticky valids on both sides, all-ones delta.
    fwd(0, 63'h00000000000000FF, 10);
    skip_hi(0, 63'h3333333333333333, 3);
    bwd(0, 63'h7FFFFFFFFFFFFFFF, 3);
    skip_lo(0, 63'h0, 3);
    chk("round_2", 0, round_cnt[0], 8'd2);

    for (int i = 3; i <= 256; i++) begin
      b7 = 7'(i);
      v  = {9{b7}};
      fwd(0, v, i % 3);
      skip_hi(0, ~v, 2 + (i % 3));
      bwd(0, v ^ 63'h0F0F0F0F0F0F0F0F, i % 2);
      skip_lo(0, v, 2);
      if (i == 255) chk("round_255", 0, round_cnt[0], 8'd255);
    end
    chk("round_wrap", 0, round_cnt[0], 8'd0);

    fwd(0, 63'h0, 0);
    skip_hi(0, 63'h1, 2);
    bwd(0, 63'h4000000000000001, 0);
    skip_lo(0, 63'h2, 2);
    chk("round_257", 0, round_cnt[0], 8'd1);

    // Reset while in FWD_DROP: outputs clear before any clock edge.
    v = 63'h6DB6DB6DB6DB6DB6;
    lo_vec_in[0] = v;
    lo_valid[0]  = 1'b1;
    begin
      exp_t x;
      x.dut = 0; x.v = v; x.c = cyc + 1;
      q_lo_ack.push_back(x);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!lo_ack[0] && n < 20);
    if (!lo_ack[0]) tmo("rst_test_ack_wait", 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_round", 0, round_cnt[0], 0);
    chk("async_rst_hi_vec", 0, hi_vec_out[0], 0);
    chk("async_rst_lo_vec", 0, lo_vec_out[0], 0);
    chk("async_rst_mult", 0, hi_mult[0], 0);
    chk("async_rst_lo_ack", 0, lo_ack[0], 0);
    chk("async_rst_phase", 0, phase[0], 0);
    lo_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_hi_vec", 0, hi_vec_out[0], 0);
    fwd(0, 63'h0246813579BDFECA, 0);

    // Lower side is the network input: no lower skip after backprop.
    fwd(1, 63'h13579BDF02468ACE, 0);
    skip_hi(1, 63'h7777777777777777, 3);
    bwd(1, 63'h0FEDCBA987654321, 0);
    @(negedge clk);
    chk("li_done_round", 1, round_cnt[1], 0);
    chk("li_done_phase", 1, phase[1], 1);
    @(negedge clk);
    chk("li_round", 1, round_cnt[1], 1);
    chk("li_phase", 1, phase[1], 0);
    fwd(1, 63'h5A5A5A5A5A5A5A5A, 0);

    repeat (5) @(negedge clk);
    chk("queues_empty", 0, q_lo_ack.size() + q_hi_ack.size() + q_mult.size() + q_bp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
